// File: rtl/int_pkg.sv
// Shared definitions for the interrupt sequencer and the interrupt controller it consumes.
package int_pkg;

  localparam int ID_W    = 2;
  localparam int NUM_SRC = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_ACK    = 3'd2,
    S_VECTOR = 3'd3,
    S_IN_ISR = 3'd4,
    S_RETURN = 3'd5
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. Clear and increment together restart the count at one.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? {{(W-1){1'b0}}, 1'b1} : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/int_sequencer.sv
// CPU-side interrupt entry/return sequencer: drain, acknowledge, vector, service, return.
module int_sequencer
  import int_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              irq,
  input  logic [ADDR_W-1:0] isr_addr,
  input  logic [ID_W-1:0]   priority_select,
  output logic              iack,
  input  logic              pipe_empty,
  input  logic [ADDR_W-1:0] resume_pc,
  input  logic              mret,
  input  logic              ie_we,
  input  logic              ie_wdata,
  output logic              stall_fetch,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              ie,
  output logic              in_isr,
  output logic [ID_W-1:0]   active_id,
  output logic [ADDR_W-1:0] epc,
  output logic [LAT_W-1:0]  last_latency,
  output state_e            state_dbg
);

  state_e             state_q;
  logic               ie_q, saved_ie_q;
  logic               stall_q, redirect_q, in_isr_q;
  logic [ADDR_W-1:0]  raddr_q, epc_q;
  logic [ID_W-1:0]    id_q;
  logic [LAT_W-1:0]   last_lat_q;
  logic [LAT_W-1:0]   lat_cnt;
  logic               take_d;
  logic               lat_clr, lat_inc;

  // A same-cycle disable write wins over a pending irq; an enable write does not help it.
  assign take_d  = irq && ie_q && !(ie_we && !ie_wdata);
  assign lat_clr = (state_q == S_IDLE) && take_d;
  assign lat_inc = lat_clr || (state_q == S_DRAIN) || (state_q == S_ACK);

  sat_counter #(.W(LAT_W)) u_lat (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (lat_clr),
    .inc_i (lat_inc),
    .cnt_o (lat_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ie_q       <= 1'b0;
      saved_ie_q <= 1'b0;
      stall_q    <= 1'b0;
      redirect_q <= 1'b0;
      in_isr_q   <= 1'b0;
      raddr_q    <= '0;
      epc_q      <= '0;
      id_q       <= '0;
      last_lat_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ie_we) ie_q <= ie_wdata;
          if (take_d) begin
            state_q <= S_DRAIN;
            stall_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (pipe_empty) begin
            epc_q   <= resume_pc;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          // Vector and id are captured now, before the controller clears on iack.
          if (irq) begin
            raddr_q    <= isr_addr;
            id_q       <= priority_select;
            redirect_q <= 1'b1;
            state_q    <= S_VECTOR;
          end else begin
            stall_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_VECTOR: begin
          saved_ie_q <= ie_q;
          ie_q       <= 1'b0;
          last_lat_q <= lat_cnt;
          redirect_q <= 1'b0;
          stall_q    <= 1'b0;
          in_isr_q   <= 1'b1;
          state_q    <= S_IN_ISR;
        end
        S_IN_ISR: begin
          if (ie_we) saved_ie_q <= ie_wdata;
          if (mret) begin
            raddr_q    <= epc_q;
            redirect_q <= 1'b1;
            state_q    <= S_RETURN;
          end
        end
        S_RETURN: begin
          ie_q       <= saved_ie_q;
          redirect_q <= 1'b0;
          in_isr_q   <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign iack          = (state_q == S_ACK) && irq;
  assign stall_fetch   = stall_q;
  assign redirect      = redirect_q;
  assign redirect_addr = raddr_q;
  assign ie            = ie_q;
  assign in_isr        = in_isr_q;
  assign active_id     = id_q;
  assign epc           = epc_q;
  assign last_latency  = last_lat_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: per-cycle vector table plus hand-written corner sequences.
module tb_int_sequencer;
  import int_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq;
  logic [31:0] isr_addr;
  logic [1:0]  priority_select;
  logic        iack;
  logic        pipe_empty;
  logic [31:0] resume_pc;
  logic        mret;
  logic        ie_we;
  logic        ie_wdata;
  logic        stall_fetch;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        ie;
  logic        in_isr;
  logic [1:0]  active_id;
  logic [31:0] epc;
  logic [15:0] last_latency;
  state_e      state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  int_sequencer #(.ADDR_W(32), .LAT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .irq             (irq),
    .isr_addr        (isr_addr),
    .priority_select (priority_select),
    .iack            (iack),
    .pipe_empty      (pipe_empty),
    .resume_pc       (resume_pc),
    .mret            (mret),
    .ie_we           (ie_we),
    .ie_wdata        (ie_wdata),
    .stall_fetch     (stall_fetch),
    .redirect        (redirect),
    .redirect_addr   (redirect_addr),
    .ie              (ie),
    .in_isr          (in_isr),
    .active_id       (active_id),
    .epc             (epc),
    .last_latency    (last_latency),
    .state_dbg       (state_dbg)
  );

  typedef struct {
    logic        irq;
    logic [31:0] isr_addr;
    logic [1:0]  psel;
    logic        pipe_empty;
    logic [31:0] resume_pc;
    logic        mret;
    logic        ie_we;
    logic        ie_wdata;
    logic        e_iack;
    logic        e_stall;
    logic        e_redirect;
    logic [31:0] e_raddr;
    logic        e_ie;
    logic        e_in_isr;
    logic        chk_ext;
    logic [1:0]  e_id;
    logic [31:0] e_epc;
    logic [15:0] e_lat;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic i_irq, input logic [31:0] i_addr, input logic [1:0] i_ps,
                       input logic i_pe, input logic [31:0] i_rpc, input logic i_mret,
                       input logic i_we, input logic i_wd);
    irq = i_irq; isr_addr = i_addr; priority_select = i_ps; pipe_empty = i_pe;
    resume_pc = i_rpc; mret = i_mret; ie_we = i_we; ie_wdata = i_wd;
  endtask

  // Outputs are compared mid-cycle, inputs are changed just after the rising edge.
  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_strobes(input string tag, input logic e_iack, input logic e_stall,
                             input logic e_redir, input logic e_ie, input logic e_in);
    chk({tag, ".iack"}, {31'd0, iack}, {31'd0, e_iack});
    chk({tag, ".stall"}, {31'd0, stall_fetch}, {31'd0, e_stall});
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, e_redir});
    chk({tag, ".ie"}, {31'd0, ie}, {31'd0, e_ie});
    chk({tag, ".in_isr"}, {31'd0, in_isr}, {31'd0, e_in});
  endtask

  initial begin
    // Basic entry/return, then a same-cycle disable write racing an irq.
    vt[0]  = '{1'b0, 32'h0,   2'd0, 1'b1, 32'h0,    1'b0, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 2'd0, 32'h0,  16'd0};
    vt[1]  = '{1'b1, 32'h100, 2'd2, 1'b1, 32'h40,   1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 2'd0, 32'h0,  16'd0};
    vt[2]  = '{1'b1, 32'h100, 2'd2, 1'b1, 32'h40,   1'b0, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 2'd0, 32'h0,  16'd0};
    vt[3]  = '{1'b1, 32'h100, 2'd2, 1'b1, 32'h40,   1'b0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 2'd0, 32'h40, 16'd0};
    vt[4]  = '{1'b0, 32'h0,   2'd0, 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 2'd2, 32'h40, 16'd0};
    vt[5]  = '{1'b0, 32'h0,   2'd0, 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 2'd2, 32'h40, 16'd3};
    vt[6]  = '{1'b0, 32'h0,   2'd0, 1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  16'd0};
    vt[7]  = '{1'b0, 32'h0,   2'd0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b1, 32'h40,  1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  16'd0};
    vt[8]  = '{1'b0, 32'h0,   2'd0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 2'd2, 32'h40, 16'd3};
    vt[9]  = '{1'b1, 32'h500, 2'd1, 1'b1, 32'h0,    1'b0, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 2'd0, 32'h0,  16'd0};
    vt[10] = '{1'b1, 32'h500, 2'd1, 1'b1, 32'h0,    1'b1, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  16'd0};

    // Reset state.
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    to_check();
    chk_strobes("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.epc", epc, 32'h0);
    chk("reset.raddr", redirect_addr, 32'h0);
    chk("reset.lat", {16'd0, last_latency}, 32'd0);
    chk("reset.id", {30'd0, active_id}, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].irq, vt[i].isr_addr, vt[i].psel, vt[i].pipe_empty, vt[i].resume_pc,
            vt[i].mret, vt[i].ie_we, vt[i].ie_wdata);
      to_check();
      chk_strobes($sformatf("vec%0d", i), vt[i].e_iack, vt[i].e_stall, vt[i].e_redirect,
                  vt[i].e_ie, vt[i].e_in_isr);
      if (vt[i].e_redirect)
        chk($sformatf("vec%0d.raddr", i), redirect_addr, vt[i].e_raddr);
      if (vt[i].chk_ext) begin
        chk($sformatf("vec%0d.id", i), {30'd0, active_id}, {30'd0, vt[i].e_id});
        chk($sformatf("vec%0d.epc", i), epc, vt[i].e_epc);
        chk($sformatf("vec%0d.lat", i), {16'd0, last_latency}, {16'd0, vt[i].e_lat});
      end
      next_cycle();
    end

    // Masked: ie=0 with irq held for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h500, 2'd1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      to_check();
      chk("mask.iack", {31'd0, iack}, 32'd0);
      chk("mask.stall", {31'd0, stall_fetch}, 32'd0);
      chk("mask.state", {29'd0, state_dbg}, {29'd0, S_IDLE});
      next_cycle();
    end

    // Drain wait: pipe_empty low for 5 DRAIN cycles.
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 32'h300, 2'd1, 1'b0, 32'h80, 1'b0, 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      to_check();
      chk("drain.stall", {31'd0, stall_fetch}, 32'd1);
      chk("drain.iack", {31'd0, iack}, 32'd0);
      next_cycle();
    end
    pipe_empty = 1'b1;
    to_check();
    chk("drain.last.iack", {31'd0, iack}, 32'd0);
    next_cycle();
    to_check();
    chk_strobes("drain.ack", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 2'd0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    to_check();
    chk_strobes("drain.vec", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("drain.raddr", redirect_addr, 32'h300);
    next_cycle();
    to_check();
    chk("drain.lat", {16'd0, last_latency}, 32'd8);
    chk("drain.epc", epc, 32'h80);
    chk("drain.id", {30'd0, active_id}, 32'd1);

    // No nesting: second irq during IN_ISR, taken only after return.
    drive(1'b1, 32'h200, 2'd3, 1'b1, 32'h90, 1'b0, 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      to_check();
      chk_strobes("nest.isr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      next_cycle();
    end
    mret = 1'b1;
    next_cycle();
    mret = 1'b0;
    to_check();
    chk_strobes("nest.ret", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("nest.ret.raddr", redirect_addr, 32'h80);
    next_cycle();
    to_check();
    chk_strobes("nest.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    to_check();
    chk("nest.drain.stall", {31'd0, stall_fetch}, 32'd1);
    next_cycle();
    to_check();
    chk("nest.ack", {31'd0, iack}, 32'd1);
    next_cycle();
    irq = 1'b0;
    to_check();
    chk("nest.vec.redirect", {31'd0, redirect}, 32'd1);
    chk("nest.vec.raddr", redirect_addr, 32'h200);
    next_cycle();
    to_check();
    chk("nest.id", {30'd0, active_id}, 32'd3);
    chk("nest.epc", epc, 32'h90);

    // Enable write inside the handler, coinciding with mret.
    drive(1'b0, 32'h0, 2'd0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 2'd0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    to_check();
    chk("isrwe.ret.raddr", redirect_addr, 32'h90);
    next_cycle();
    drive(1'b1, 32'h600, 2'd0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      to_check();
      chk_strobes("isrwe.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end

    // Reset mid-sequence during DRAIN.
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 32'h700, 2'd2, 1'b0, 32'hA0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    to_check();
    chk("rst.drain.stall", {31'd0, stall_fetch}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_strobes("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    #1 rst_n = 1'b1;
    next_cycle();
    pipe_empty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      to_check();
      chk_strobes("rst.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    ie_we = 1'b1; ie_wdata = 1'b1;
    next_cycle();
    ie_we = 1'b0;
    next_cycle();
    to_check();
    chk("rst.retake.stall", {31'd0, stall_fetch}, 32'd1);
    next_cycle();
    to_check();
    chk("rst.retake.iack", {31'd0, iack}, 32'd1);
    next_cycle();
    irq = 1'b0;
    to_check();
    chk("rst.retake.raddr", redirect_addr, 32'h700);
    chk("rst.retake.redirect", {31'd0, redirect}, 32'd1);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
